// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and defaults for the ALU command interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    NOP = 3'b000,
    ADD = 3'b001,
    AND = 3'b010,
    XOR = 3'b011,
    MUL = 3'b100
  } op_e;

  // ISSUE is folded into IDLE today; its encoding is reserved for a multi-cycle issue path.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } req_state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_DRAIN   = 4;

  function automatic logic is_nop(input logic [2:0] op);
    return op == NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous command FIFO of cmd_t entries with push/pop flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int c_AW = $clog2(DEPTH);

  cmd_t            r_mem [DEPTH];
  logic [c_AW:0]   r_wptr;
  logic [c_AW:0]   r_rptr;
  logic            w_do_push;
  logic            w_do_pop;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/alu_requester.sv
// ============================================================================
// Module      : alu_requester
// Description : Buffers host commands, issues them to the ALU one at a time
//               and returns results on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_requester
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DRAIN   = DEF_DRAIN
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_timeout,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  localparam int c_TMO_W = $clog2(TIMEOUT + 1);
  localparam int c_DRN_W = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX  = c_TMO_W'(TIMEOUT);
  localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(DRAIN - 1);

  cmd_t  w_push_data;
  cmd_t  w_head;
  logic  w_fifo_full;
  logic  w_fifo_empty;
  logic  w_pop;

  req_state_e         r_state,       w_state_nxt;
  logic [c_TMO_W-1:0] r_tmo_cnt,     w_tmo_nxt;
  logic [c_DRN_W-1:0] r_drn_cnt,     w_drn_nxt;
  logic [7:0]         r_alu_a,       w_alu_a_nxt;
  logic [7:0]         r_alu_b,       w_alu_b_nxt;
  logic [2:0]         r_alu_op,      w_alu_op_nxt;
  logic               r_alu_start,   w_alu_start_nxt;
  logic [15:0]        r_rsp_result,  w_rsp_result_nxt;
  logic [2:0]         r_rsp_op,      w_rsp_op_nxt;
  logic               r_rsp_timeout, w_rsp_timeout_nxt;

  assign w_push_data = {cmd_a, cmd_b, cmd_op};
  assign cmd_ready   = !w_fifo_full;

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_tmo_cnt     <= '0;
      r_drn_cnt     <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_alu_start   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_op      <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tmo_cnt     <= w_tmo_nxt;
      r_drn_cnt     <= w_drn_nxt;
      r_alu_a       <= w_alu_a_nxt;
      r_alu_b       <= w_alu_b_nxt;
      r_alu_op      <= w_alu_op_nxt;
      r_alu_start   <= w_alu_start_nxt;
      r_rsp_result  <= w_rsp_result_nxt;
      r_rsp_op      <= w_rsp_op_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_tmo_nxt         = r_tmo_cnt;
    w_drn_nxt         = r_drn_cnt;
    w_alu_a_nxt       = r_alu_a;
    w_alu_b_nxt       = r_alu_b;
    w_alu_op_nxt      = r_alu_op;
    w_alu_start_nxt   = r_alu_start;
    w_rsp_result_nxt  = r_rsp_result;
    w_rsp_op_nxt      = r_rsp_op;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_pop             = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_rsp_op_nxt = w_head.op;
          if (is_nop(w_head.op)) begin
            w_rsp_result_nxt  = '0;
            w_rsp_timeout_nxt = 1'b0;
            w_state_nxt       = RESP;
          end else begin
            w_alu_a_nxt     = w_head.a;
            w_alu_b_nxt     = w_head.b;
            w_alu_op_nxt    = w_head.op;
            w_alu_start_nxt = 1'b1;
            w_tmo_nxt       = '0;
            w_state_nxt     = WAIT;
          end
        end
      end

      WAIT: begin
        // A done sampled on the last allowed cycle still wins over the timeout.
        if (alu_done) begin
          w_rsp_result_nxt  = alu_result;
          w_rsp_timeout_nxt = 1'b0;
          w_alu_start_nxt   = 1'b0;
          w_state_nxt       = RESP;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_rsp_result_nxt  = '0;
          w_rsp_timeout_nxt = 1'b1;
          w_alu_start_nxt   = 1'b0;
          w_state_nxt       = RESP;
        end else if (r_tmo_cnt != c_TMO_MAX) begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          if (is_nop(r_rsp_op) || (DRAIN == 0)) begin
            w_state_nxt = IDLE;
          end else begin
            w_drn_nxt   = '0;
            w_state_nxt = alu_pkg::DRAIN;
          end
        end
      end

      alu_pkg::DRAIN: begin
        if (r_drn_cnt == c_DRN_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_drn_nxt = r_drn_cnt + 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign rsp_valid   = (r_state == RESP);
  assign rsp_result  = r_rsp_result;
  assign rsp_op      = r_rsp_op;
  assign rsp_timeout = r_rsp_timeout;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign busy        = (r_state != IDLE) || !w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_alu_requester.sv
// ============================================================================
// Module      : tb_alu_requester
// Description : Directed bench for alu_requester with a small ALU responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_requester;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  alu_requester #(
    .DEPTH   (4),
    .TIMEOUT (16),
    .DRAIN   (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_op      (rsp_op),
    .rsp_timeout (rsp_timeout),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // ALU responder: one-cycle ops answer one cycle after start, MUL after four
  // with a trailing second done pulse. It ignores reset so late dones can occur.
  logic        alu_dead = 1'b0;
  logic        start_q = 1'b0;
  logic        sc_done = 1'b0;
  logic        d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, d4 = 1'b0, d5 = 1'b0;
  logic [15:0] res_q = '0;
  logic        rise;

  function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    if (op[2]) return a * b;
    case (op[1:0])
      2'b01:   return {8'h00, a} + {8'h00, b};
      2'b10:   return {8'h00, a & b};
      2'b11:   return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  assign rise       = alu_start && !start_q;
  assign alu_done   = sc_done | d4 | d5;
  assign alu_result = res_q;

  always @(posedge clk) begin
    start_q <= alu_start;
    sc_done <= rise && !alu_op[2] && !alu_dead;
    d1      <= rise && alu_op[2] && !alu_dead;
    d2      <= d1;
    d3      <= d2;
    d4      <= d3;
    d5      <= d4;
    if (rise) res_q <= alu_calc(alu_a, alu_b, alu_op);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic rdy;
    int   n;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    rdy       = 1'b0;
    n         = 0;
    while (!rdy && n < 60) begin
      rdy = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!rdy) check("push_accept", 16'(rdy), 16'h1);
  endtask

  task automatic wait_rsp(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!rsp_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 16'(rsp_valid), 16'h1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("wait_idle", 16'(busy), 16'h0);
  endtask

  logic [15:0] exp_res [6] = '{16'h0003, 16'h0030, 16'h00F0, 16'h0100, 16'h01FE, 16'h0000};
  logic [2:0]  exp_op  [6] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001, 3'b000};

  initial begin
    int gap;
    int extra;
    int got;
    logic acc;

    // Reset state
    tick(); tick(); tick();
    check("rst_cmd_ready", 16'(cmd_ready), 16'h1);
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rst_alu_start", 16'(alu_start), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_rsp_result", rsp_result, 16'h0000);
    check("rst_alu_ops", {alu_a, alu_b}, 16'h0000);
    reset_n = 1'b1;
    tick();

    // ADD 0x12 + 0x34
    rsp_ready = 1'b1;
    push(8'h12, 8'h34, 3'b001);
    tick();
    check("add_start", 16'(alu_start), 16'h1);
    check("add_done_late", 16'(alu_done), 16'h0);
    check("add_alu_ab", {alu_a, alu_b}, 16'h1234);
    check("add_alu_op", 16'(alu_op), 16'h1);
    tick();
    check("add_done", 16'(alu_done), 16'h1);
    check("add_start_held", 16'(alu_start), 16'h1);
    check("add_rsp_early", 16'(rsp_valid), 16'h0);
    tick();
    check("add_rsp_valid", 16'(rsp_valid), 16'h1);
    check("add_rsp_result", rsp_result, 16'h0046);
    check("add_rsp_op", 16'(rsp_op), 16'h1);
    check("add_rsp_tmo", 16'(rsp_timeout), 16'h0);
    check("add_start_off", 16'(alu_start), 16'h0);
    tick();
    check("add_rsp_drop", 16'(rsp_valid), 16'h0);
    wait_idle();

    // MUL then XOR back to back
    push(8'hFF, 8'hFF, 3'b100);
    push(8'hF0, 8'h3C, 3'b011);
    check("mul_start", 16'(alu_start), 16'h1);
    check("mul_alu_op", 16'(alu_op), 16'h4);
    tick(); tick(); tick(); tick();
    check("mul_rsp_early", 16'(rsp_valid), 16'h0);
    tick();
    check("mul_rsp_valid", 16'(rsp_valid), 16'h1);
    check("mul_rsp_result", rsp_result, 16'hFE01);
    check("mul_rsp_op", 16'(rsp_op), 16'h4);
    gap = 0;
    while (!alu_start && gap < 30) begin
      gap++;
      tick();
    end
    check("xor_start", 16'(alu_start), 16'h1);
    check("drain_gap_ok", 16'(gap >= 4), 16'h1);
    check("xor_alu_op", 16'(alu_op), 16'h3);
    wait_rsp("xor_rsp_wait", 20);
    check("xor_rsp_result", rsp_result, 16'h00CC);
    check("xor_rsp_op", 16'(rsp_op), 16'h3);
    tick();
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) extra++;
      tick();
    end
    check("no_third_rsp", 16'(extra), 16'h0);
    wait_idle();

    // NOP bypass
    push(8'h55, 8'hAA, 3'b000);
    check("nop_no_start0", 16'(alu_start), 16'h0);
    tick();
    check("nop_rsp_valid", 16'(rsp_valid), 16'h1);
    check("nop_rsp_result", rsp_result, 16'h0000);
    check("nop_rsp_op", 16'(rsp_op), 16'h0);
    check("nop_no_start1", 16'(alu_start), 16'h0);
    tick();
    check("nop_rsp_drop", 16'(rsp_valid), 16'h0);
    check("nop_idle", 16'(busy), 16'h0);

    // Six commands with back-pressure on the response port
    rsp_ready = 1'b0;
    push(8'h01, 8'h02, 3'b001);
    push(8'hF0, 8'h3C, 3'b010);
    push(8'h0F, 8'hFF, 3'b011);
    push(8'h10, 8'h10, 3'b100);
    push(8'hFF, 8'hFF, 3'b001);
    check("bp_cmd_ready_full", 16'(cmd_ready), 16'h0);
    check("bp_busy", 16'(busy), 16'h1);
    cmd_valid = 1'b1;
    cmd_a     = 8'h77;
    cmd_b     = 8'h88;
    cmd_op    = 3'b000;
    tick(); tick(); tick();
    check("bp_cmd_ready_hold", 16'(cmd_ready), 16'h0);
    check("bp_rsp_hold", 16'(rsp_valid), 16'h1);
    check("bp_rsp_stable", rsp_result, 16'h0003);
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
      if (rsp_valid) begin
        check($sformatf("bp_result%0d", got), rsp_result, exp_res[got]);
        check($sformatf("bp_op%0d", got), 16'(rsp_op), 16'(exp_op[got]));
        got++;
      end
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    check("bp_rsp_count", 16'(got), 16'h6);
    wait_idle();

    // Done never arrives: timeout, then a normal op
    rsp_ready = 1'b0;
    alu_dead  = 1'b1;
    push(8'h0F, 8'hF3, 3'b010);
    tick();
    check("tmo_start", 16'(alu_start), 16'h1);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_rsp_early", 16'(rsp_valid), 16'h0);
    tick();
    check("tmo_rsp_valid", 16'(rsp_valid), 16'h1);
    check("tmo_flag", 16'(rsp_timeout), 16'h1);
    check("tmo_result", rsp_result, 16'h0000);
    check("tmo_op", 16'(rsp_op), 16'h2);
    check("tmo_start_off", 16'(alu_start), 16'h0);
    rsp_ready = 1'b1;
    alu_dead  = 1'b0;
    tick();
    push(8'hAA, 8'h55, 3'b011);
    wait_rsp("post_tmo_wait", 30);
    check("post_tmo_result", rsp_result, 16'h00FF);
    check("post_tmo_flag", 16'(rsp_timeout), 16'h0);
    tick();
    wait_idle();

    // Reset in WAIT of a MUL with another command queued
    push(8'h03, 8'h05, 3'b100);
    push(8'h01, 8'h01, 3'b001);
    check("rw_start", 16'(alu_start), 16'h1);
    tick();
    reset_n = 1'b0;
    tick();
    check("rw_start_off", 16'(alu_start), 16'h0);
    check("rw_rsp_valid", 16'(rsp_valid), 16'h0);
    check("rw_cmd_ready", 16'(cmd_ready), 16'h1);
    check("rw_fifo_empty", 16'(busy), 16'h0);
    reset_n = 1'b1;
    extra = 0;
    gap   = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) extra++;
      if (alu_start) gap++;
      tick();
    end
    check("rw_late_done_ignored", 16'(extra), 16'h0);
    check("rw_no_reissue", 16'(gap), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
